// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit interface: the pipeline-stage fields the hazard controller
// observes, plus the forwarding selects, stall/flush enables and status it
// returns. The pipeline side uses "master"; the controller uses "slave".
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // Decode / Execute / Memory / Writeback observation
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic              load_e;
    logic              mc_start_e;
    logic              pcsrc_e;
    logic [REG_AW-1:0] rd_m;
    logic              regwrite_m;
    logic [REG_AW-1:0] rd_w;
    logic              regwrite_w;

    // Controls and status back to the pipeline
    logic [1:0]        fwd_a_e;
    logic [1:0]        fwd_b_e;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              flush_d;
    logic              flush_e;
    logic              flush_m;
    logic              mc_busy;
    logic              mc_done;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, mc_start_e, pcsrc_e,
               rd_m, regwrite_m, rd_w, regwrite_w,
        input  fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, flush_d, flush_e,
               flush_m, mc_busy, mc_done, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, mc_start_e, pcsrc_e,
               rd_m, regwrite_m, rd_w, regwrite_w,
        output fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, flush_d, flush_e,
               flush_m, mc_busy, mc_done, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: operand forwarding,
// load-use stalls, branch flushes, a multi-cycle execute sequencer that holds
// F/D/E for MC_LAT cycles, and saturating stall/flush performance counters.
// Optional feature macro: HAZARD_PERF_CNT_EN (counters built when defined,
// outputs tied to zero otherwise).
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 8,   // legal 2..255
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    // BUSY lasts MC_LAT-1 cycles; the start cycle supplies the remaining stall.
    localparam logic [7:0]        CNT_INIT = 8'(MC_LAT - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    mc_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mc_busy_q, mc_done_q;

    logic       mc_go;
    logic       mc_hold;
    logic       lw_stall;
    logic       lw_stall_eff;
    logic       br_flush;
    logic       stall_fd;

    // Memory-stage result beats Writeback; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && (rd_m != REG_ZERO) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != REG_ZERO) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Operand forwarding selects for both Execute operands
    always_comb begin
        hz.fwd_a_e = fwd_sel(hz.rs1_e, hz.rd_m, hz.regwrite_m, hz.rd_w, hz.regwrite_w);
        hz.fwd_b_e = fwd_sel(hz.rs2_e, hz.rd_m, hz.regwrite_m, hz.rd_w, hz.regwrite_w);
    end

    // Stall/flush arbitration: a multi-cycle op in its start or BUSY cycles
    // owns the pipeline and masks load-use and branch requests. Start is
    // gated by rst so an in-flight reset releases every stall at once.
    always_comb begin
        mc_go        = (state_q == IDLE) && hz.mc_start_e && !rst;
        mc_hold      = mc_go || (state_q == BUSY);
        lw_stall     = hz.load_e && (hz.rd_e != REG_ZERO) &&
                       ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
        lw_stall_eff = lw_stall && !mc_hold;
        br_flush     = hz.pcsrc_e && !mc_hold;
        stall_fd     = lw_stall_eff || mc_hold;

        hz.stall_f   = stall_fd;
        hz.stall_d   = stall_fd;
        hz.stall_e   = mc_hold;
        hz.flush_d   = br_flush;
        hz.flush_e   = lw_stall_eff || br_flush;
        hz.flush_m   = mc_hold;
        hz.mc_busy   = mc_busy_q;
        hz.mc_done   = mc_done_q;
    end

    // Multi-cycle sequencer next state: IDLE -> BUSY (count down) -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mc_go) begin
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0)
                    state_d = DONE;
                else
                    cnt_d = cnt_q - 8'd1;
            end
            DONE:    state_d = IDLE;   // start requests are ignored here
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state with registered busy/done status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            mc_busy_q <= 1'b0;
            mc_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mc_busy_q <= (state_d != IDLE);
            mc_done_q <= (state_d == DONE);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: stop at all-ones rather than wrap
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fd && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (hz.pcsrc_e && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver applies one stimulus
// vector per cycle and queues the expected outputs from a cycle-age model;
// a monitor on the falling edge pops and compares.
module tb_pipeline_hazard_ctrl;
    localparam int REG_AW = 5;
    localparam int MC_LAT = 8;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        logic r, ld, mc, pc, rwm, rww;
        logic [4:0] r1d, r2d, r1e, r2e, rde, rdm, rdw;
    } stim_t;

    typedef struct {
        logic [1:0] fa, fb;
        logic sf, sd, se, fd, fe, fm, busy, done;
        int scnt, fcnt;
        string tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Model state: age is -1 when no op is in Execute, otherwise the number
    // of cycles since the op started (1..MC_LAT); stalls cover the start
    // cycle and ages 1..MC_LAT-1, the result appears at age MC_LAT.
    int age = -1;
    int m_scnt = 0;
    int m_fcnt = 0;

    function automatic logic [1:0] fwd(input logic [4:0] rs, input stim_t s);
        if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
        if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle_s();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want, input string tag);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s %s got=%0h want=%0h", tag, name, act, want);
        end
    endtask

    task automatic cyc(input stim_t s, input string tag);
        exp_t e;
        bit hold, lw, br, start;
        @(posedge clk);
        #1;
        rst           = s.r;
        hz.load_e     = s.ld;
        hz.mc_start_e = s.mc;
        hz.pcsrc_e    = s.pc;
        hz.rs1_d      = s.r1d;
        hz.rs2_d      = s.r2d;
        hz.rs1_e      = s.r1e;
        hz.rs2_e      = s.r2e;
        hz.rd_e       = s.rde;
        hz.rd_m       = s.rdm;
        hz.regwrite_m = s.rwm;
        hz.rd_w       = s.rdw;
        hz.regwrite_w = s.rww;

        e.tag = tag;
        e.fa  = fwd(s.r1e, s);
        e.fb  = fwd(s.r2e, s);
        if (s.r) begin
            {e.sf, e.sd, e.se, e.fd, e.fe, e.fm, e.busy, e.done} = '0;
            e.scnt = 0;
            e.fcnt = 0;
            age = -1; m_scnt = 0; m_fcnt = 0;
        end else begin
            start  = (age < 0) && s.mc;
            hold   = start || (age >= 1 && age < MC_LAT);
            lw     = s.ld && s.rde != 0 && (s.rde == s.r1d || s.rde == s.r2d) && !hold;
            br     = s.pc && !hold;
            e.sf   = hold || lw;
            e.sd   = hold || lw;
            e.se   = hold;
            e.fd   = br;
            e.fe   = lw || br;
            e.fm   = hold;
            e.busy = (age >= 1);
            e.done = (age == MC_LAT);
`ifdef HAZARD_PERF_CNT_EN
            e.scnt = m_scnt;
            e.fcnt = m_fcnt;
`else
            e.scnt = 0;
            e.fcnt = 0;
`endif
            if (e.sf && m_scnt < CMAX) m_scnt++;
            if (s.pc && m_fcnt < CMAX) m_fcnt++;
            if (start)              age = 1;
            else if (age == MC_LAT) age = -1;
            else if (age >= 1)      age++;
        end
        q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("fwd_a_e",   32'(hz.fwd_a_e),   32'(e.fa),   e.tag);
            chk("fwd_b_e",   32'(hz.fwd_b_e),   32'(e.fb),   e.tag);
            chk("stall_f",   32'(hz.stall_f),   32'(e.sf),   e.tag);
            chk("stall_d",   32'(hz.stall_d),   32'(e.sd),   e.tag);
            chk("stall_e",   32'(hz.stall_e),   32'(e.se),   e.tag);
            chk("flush_d",   32'(hz.flush_d),   32'(e.fd),   e.tag);
            chk("flush_e",   32'(hz.flush_e),   32'(e.fe),   e.tag);
            chk("flush_m",   32'(hz.flush_m),   32'(e.fm),   e.tag);
            chk("mc_busy",   32'(hz.mc_busy),   32'(e.busy), e.tag);
            chk("mc_done",   32'(hz.mc_done),   32'(e.done), e.tag);
            chk("stall_cnt", 32'(hz.stall_cnt), 32'(e.scnt), e.tag);
            chk("flush_cnt", 32'(hz.flush_cnt), 32'(e.fcnt), e.tag);
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        hz.load_e = 0; hz.mc_start_e = 0; hz.pcsrc_e = 0;
        hz.rs1_d = 0; hz.rs2_d = 0; hz.rs1_e = 0; hz.rs2_e = 0; hz.rd_e = 0;
        hz.rd_m = 0; hz.regwrite_m = 0; hz.rd_w = 0; hz.regwrite_w = 0;

        // Reset state, then quiet pipeline
        s = idle_s(); s.r = 1;
        cyc(s, "reset");
        s = idle_s();
        cyc(s, "quiet");

        // Forwarding priority and x0 exclusion
        s = idle_s(); s.r1e = 5; s.r2e = 5; s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1;
        cyc(s, "fwd_mem");
        s.rwm = 0;
        cyc(s, "fwd_wb");
        s = idle_s(); s.r1e = 0; s.rdm = 0; s.rwm = 1;
        cyc(s, "fwd_x0");
        s = idle_s(); s.r2e = 9; s.rdw = 9; s.rww = 1; s.r1e = 4; s.rdm = 4; s.rwm = 1;
        cyc(s, "fwd_mix");

        // Load-use stall, and none for rd_e=0
        s = idle_s(); s.ld = 1; s.rde = 7; s.r2d = 7;
        cyc(s, "loaduse");
        s = idle_s();
        cyc(s, "loaduse_after");
        s = idle_s(); s.ld = 1; s.rde = 0; s.r1d = 0; s.r2d = 0;
        cyc(s, "loaduse_x0");

        // Branch flush
        s = idle_s(); s.pc = 1;
        cyc(s, "branch");
        s = idle_s();
        cyc(s, "branch_after");

        // Multi-cycle op with concurrent load-use and branch during the stall
        for (int i = 0; i <= MC_LAT; i++) begin
            s = idle_s(); s.mc = 1;
            if (i == 3) begin s.ld = 1; s.rde = 3; s.r1d = 3; end
            if (i == 5) s.pc = 1;
            cyc(s, $sformatf("mc_c%0d", i));
        end
        s = idle_s();
        cyc(s, "mc_idle");
        cyc(s, "mc_idle2");

        // Reset on the third BUSY cycle
        for (int i = 0; i < 4; i++) begin
            s = idle_s(); s.mc = 1; s.r = (i == 3);
            cyc(s, $sformatf("rst_mid_c%0d", i));
        end
        s = idle_s();
        cyc(s, "rst_mid_after");

        // Counter saturation: 20 stall cycles then hold
        for (int i = 0; i < 20; i++) begin
            s = idle_s(); s.ld = 1; s.rde = 1; s.r1d = 1;
            cyc(s, "sat");
        end
        s = idle_s();
        cyc(s, "sat_hold");
        cyc(s, "sat_hold2");

        // Randomized traffic
        s = idle_s(); s.r = 1;
        cyc(s, "rnd_reset");
        for (int i = 0; i < 600; i++) begin
            s = idle_s();
            s.r   = ($urandom_range(0, 59) == 0);
            s.mc  = ($urandom_range(0, 9) == 0);
            s.r1e = 5'($urandom_range(0, 3));
            s.r2e = 5'($urandom_range(0, 3));
            s.rdm = 5'($urandom_range(0, 3));
            s.rdw = 5'($urandom_range(0, 3));
            s.rwm = 1'($urandom_range(0, 1));
            s.rww = 1'($urandom_range(0, 1));
            if (!s.r) begin
                s.ld  = ($urandom_range(0, 3) == 0);
                s.pc  = !s.ld && ($urandom_range(0, 5) == 0);
                s.r1d = 5'($urandom_range(0, 3));
                s.r2d = 5'($urandom_range(0, 3));
                s.rde = 5'($urandom_range(0, 3));
            end
            cyc(s, "random");
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
